agent_gridworld: RTL and testbench

Parametrised successor to the Q-learning agent. It owns the episode loop for a GRID_W x GRID_H grid world. Each step it requests a random draw, picks an action with an epsilon-greedy rule, and computes the next state with wall clamping. It hands the (state, action, next-state) transition to the Q-update stage through a valid/ready handshake. Episode termination (goal or step limit), per-episode epsilon decay and run completion are handled internally.

---
 rtl/agent_pkg.sv | 41 ++++
 rtl/grid_step.sv | 60 ++++++
 rtl/agent_gridworld.sv | 194 +++++++++++++++++++
 tb/tb_agent_gridworld.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agent_pkg.sv
// -----------------------------------------------------------------------------
// agent_pkg
// Shared definitions for the grid-world agent:
//   - action encoding (up/down/left/right)
//   - episode-loop FSM state type
//   - default grid, episode and epsilon-schedule parameters
// -----------------------------------------------------------------------------
package agent_pkg;

    // Action encoding
    localparam int ACT_UP    = 0;
    localparam int ACT_DOWN  = 1;
    localparam int ACT_LEFT  = 2;
    localparam int ACT_RIGHT = 3;

    // Episode-loop FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEL  = 2'd2,
        ST_OUT  = 2'd3
    } fsm_state_t;

    // Default grid / run parameters
    localparam int DEF_GRID_W        = 4;
    localparam int DEF_GRID_H        = 4;
    localparam int DEF_STATES_WIDTH  = 4;
    localparam int DEF_ACTIONS_WIDTH = 2;
    localparam int DEF_GOAL_ST       = 15;
    localparam int DEF_MAX_STEPS     = 64;
    localparam int DEF_STEP_WIDTH    = 7;
    localparam int DEF_N_EPISODES    = 300;
    localparam int DEF_COUNTER_WIDTH = 10;

    // Default epsilon schedule
    localparam int DEF_EPS_WIDTH     = 8;
    localparam int DEF_EPS_INIT      = 255;
    localparam int DEF_EPS_MIN       = 16;
    localparam int DEF_EPS_DEC       = 1;

endpackage

// File: rtl/grid_step.sv
// -----------------------------------------------------------------------------
// grid_step
// Combinational move of one cell on a GRID_W x GRID_H grid. A move that would
// leave the grid keeps the position unchanged.
// Ports:
//   row, col   in   current position
//   act        in   action (up/down/left/right)
//   next_row   out  row after the move
//   next_col   out  column after the move
//   cur_st     out  row*GRID_W + col of the current position
//   next_st    out  row*GRID_W + col of the new position
//   is_goal    out  next_st equals GOAL_ST
// -----------------------------------------------------------------------------
module grid_step
    import agent_pkg::*;
#(
    parameter int GRID_W        = DEF_GRID_W,
    parameter int GRID_H        = DEF_GRID_H,
    parameter int STATES_WIDTH  = DEF_STATES_WIDTH,
    parameter int ACTIONS_WIDTH = DEF_ACTIONS_WIDTH,
    parameter int GOAL_ST       = DEF_GOAL_ST
) (
    input  logic [STATES_WIDTH-1:0]  row,
    input  logic [STATES_WIDTH-1:0]  col,
    input  logic [ACTIONS_WIDTH-1:0] act,
    output logic [STATES_WIDTH-1:0]  next_row,
    output logic [STATES_WIDTH-1:0]  next_col,
    output logic [STATES_WIDTH-1:0]  cur_st,
    output logic [STATES_WIDTH-1:0]  next_st,
    output logic                     is_goal
);

    always_comb begin
        next_row = row;
        next_col = col;
        case (act)
            ACTIONS_WIDTH'(ACT_UP): begin
                if (row != '0) next_row = row - STATES_WIDTH'(1);
            end
            ACTIONS_WIDTH'(ACT_DOWN): begin
                if (int'(row) < GRID_H - 1) next_row = row + STATES_WIDTH'(1);
            end
            ACTIONS_WIDTH'(ACT_LEFT): begin
                if (col != '0) next_col = col - STATES_WIDTH'(1);
            end
            ACTIONS_WIDTH'(ACT_RIGHT): begin
                if (int'(col) < GRID_W - 1) next_col = col + STATES_WIDTH'(1);
            end
            default: begin
                next_row = row;
                next_col = col;
            end
        endcase
    end

    assign cur_st  = STATES_WIDTH'(int'(row) * GRID_W + int'(col));
    assign next_st = STATES_WIDTH'(int'(next_row) * GRID_W + int'(next_col));
    assign is_goal = (next_st == STATES_WIDTH'(GOAL_ST));

endmodule

// File: rtl/agent_gridworld.sv
// -----------------------------------------------------------------------------
// agent_gridworld
// Episode loop of an epsilon-greedy grid-world agent. Each step requests a
// random draw, picks an action, computes the clamped next state and offers the
// (state, action, next-state) transition downstream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid           start pulse, honoured in IDLE only
//   i_first_st        start state of every episode (latched at start)
//   i_at_max          greedy action for the current state
//   i_at_random       random action
//   i_rand            random draw compared against epsilon
//   i_ready           downstream accepts the transition
//   o_st, o_at,
//   o_next_st, o_done transition payload (o_done: last step of the episode)
//   o_valid           transition valid
//   o_re_random       one-cycle request to the random source
//   o_episode         completed episodes
//   o_eps             current epsilon
//   o_busy            run in progress
//   o_finish          one-cycle pulse after the final episode
//
// Handshake: a transition is transferred on a rising clk edge where
// o_valid && i_ready. While o_valid is high and i_ready low, the payload
// (o_st, o_at, o_next_st, o_done) is held stable. o_valid never drops
// without a transfer except on reset. The random source must present
// i_rand / i_at_max / i_at_random in the cycle after o_re_random.
// -----------------------------------------------------------------------------
module agent_gridworld
    import agent_pkg::*;
#(
    parameter int GRID_W        = DEF_GRID_W,
    parameter int GRID_H        = DEF_GRID_H,
    parameter int STATES_WIDTH  = DEF_STATES_WIDTH,
    parameter int ACTIONS_WIDTH = DEF_ACTIONS_WIDTH,
    parameter int GOAL_ST       = DEF_GOAL_ST,
    parameter int MAX_STEPS     = DEF_MAX_STEPS,
    parameter int STEP_WIDTH    = DEF_STEP_WIDTH,
    parameter int N_EPISODES    = DEF_N_EPISODES,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int EPS_WIDTH     = DEF_EPS_WIDTH,
    parameter int EPS_INIT      = DEF_EPS_INIT,
    parameter int EPS_MIN       = DEF_EPS_MIN,
    parameter int EPS_DEC       = DEF_EPS_DEC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [STATES_WIDTH-1:0]  i_first_st,
    input  logic [ACTIONS_WIDTH-1:0] i_at_max,
    input  logic [ACTIONS_WIDTH-1:0] i_at_random,
    input  logic [EPS_WIDTH-1:0]     i_rand,
    input  logic                     i_ready,
    output logic [STATES_WIDTH-1:0]  o_st,
    output logic [STATES_WIDTH-1:0]  o_next_st,
    output logic [ACTIONS_WIDTH-1:0] o_at,
    output logic                     o_done,
    output logic                     o_valid,
    output logic                     o_re_random,
    output logic [COUNTER_WIDTH-1:0] o_episode,
    output logic [EPS_WIDTH-1:0]     o_eps,
    output logic                     o_busy,
    output logic                     o_finish
);

    localparam int N_CELLS = GRID_W * GRID_H;

    fsm_state_t state_q, state_d;

    logic [STATES_WIDTH-1:0]  cur_row, cur_col;
    logic [STATES_WIDTH-1:0]  first_row, first_col;
    logic [STATES_WIDTH-1:0]  nxt_row_q, nxt_col_q;
    logic [STEP_WIDTH-1:0]    step_cnt;
    logic [STATES_WIDTH-1:0]  start_st;
    logic [ACTIONS_WIDTH-1:0] act_sel;
    logic [STATES_WIDTH-1:0]  gs_next_row, gs_next_col, gs_cur_st, gs_next_st;
    logic                     gs_goal;
    logic                     step_limit;
    logic [COUNTER_WIDTH-1:0] episode_inc;
    logic                     last_episode;

    // Out-of-grid start states fall back to cell 0.
    assign start_st     = (int'(i_first_st) >= N_CELLS) ? '0 : i_first_st;
    // Strict compare: eps = 0 never explores.
    assign act_sel      = (i_rand < o_eps) ? i_at_random : i_at_max;
    assign step_limit   = (step_cnt == STEP_WIDTH'(MAX_STEPS - 1));
    assign episode_inc  = o_episode + COUNTER_WIDTH'(1);
    assign last_episode = (episode_inc == COUNTER_WIDTH'(N_EPISODES));

    grid_step #(
        .GRID_W        (GRID_W),
        .GRID_H        (GRID_H),
        .STATES_WIDTH  (STATES_WIDTH),
        .ACTIONS_WIDTH (ACTIONS_WIDTH),
        .GOAL_ST       (GOAL_ST)
    ) u_grid_step (
        .row      (cur_row),
        .col      (cur_col),
        .act      (act_sel),
        .next_row (gs_next_row),
        .next_col (gs_next_col),
        .cur_st   (gs_cur_st),
        .next_st  (gs_next_st),
        .is_goal  (gs_goal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = ST_REQ;
            ST_REQ:  state_d = ST_SEL;
            ST_SEL:  state_d = ST_OUT;
            ST_OUT: begin
                if (i_ready) state_d = (o_done && last_episode) ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_re_random = (state_q == ST_REQ);
    assign o_valid     = (state_q == ST_OUT);
    assign o_busy      = (state_q != ST_IDLE);

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_row   <= '0;
            cur_col   <= '0;
            first_row <= '0;
            first_col <= '0;
            nxt_row_q <= '0;
            nxt_col_q <= '0;
            step_cnt  <= '0;
            o_st      <= '0;
            o_next_st <= '0;
            o_at      <= '0;
            o_done    <= 1'b0;
            o_episode <= '0;
            o_eps     <= EPS_WIDTH'(EPS_INIT);
            o_finish  <= 1'b0;
        end else begin
            o_finish <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        first_row <= STATES_WIDTH'(int'(start_st) / GRID_W);
                        first_col <= STATES_WIDTH'(int'(start_st) % GRID_W);
                        cur_row   <= STATES_WIDTH'(int'(start_st) / GRID_W);
                        cur_col   <= STATES_WIDTH'(int'(start_st) % GRID_W);
                        step_cnt  <= '0;
                        o_episode <= '0;
                        o_eps     <= EPS_WIDTH'(EPS_INIT);
                    end
                end
                ST_SEL: begin
                    o_st      <= gs_cur_st;
                    o_at      <= act_sel;
                    o_next_st <= gs_next_st;
                    nxt_row_q <= gs_next_row;
                    nxt_col_q <= gs_next_col;
                    o_done    <= gs_goal || step_limit;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        if (!o_done) begin
                            cur_row  <= nxt_row_q;
                            cur_col  <= nxt_col_q;
                            step_cnt <= step_cnt + STEP_WIDTH'(1);
                        end else begin
                            cur_row   <= first_row;
                            cur_col   <= first_col;
                            step_cnt  <= '0;
                            o_episode <= episode_inc;
                            if (int'(o_eps) >= EPS_MIN + EPS_DEC)
                                o_eps <= o_eps - EPS_WIDTH'(EPS_DEC);
                            else
                                o_eps <= EPS_WIDTH'(EPS_MIN);
                            o_finish  <= last_episode;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_agent_gridworld.sv
// -----------------------------------------------------------------------------
// tb_agent_gridworld
// Directed bench for agent_gridworld. Instance dut uses the default
// parameters; instance dut_lim uses MAX_STEPS=4, N_EPISODES=2, EPS_INIT=16 to
// reach the step and episode limits quickly.
// -----------------------------------------------------------------------------
module tb_agent_gridworld;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- default instance ----------------
    logic       i_valid;
    logic [3:0] i_first_st;
    logic [1:0] i_at_max, i_at_random;
    logic [7:0] i_rand;
    logic       i_ready;
    logic [3:0] o_st, o_next_st;
    logic [1:0] o_at;
    logic       o_done, o_valid, o_re_random, o_busy, o_finish;
    logic [9:0] o_episode;
    logic [7:0] o_eps;

    agent_gridworld dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_first_st  (i_first_st),
        .i_at_max    (i_at_max),
        .i_at_random (i_at_random),
        .i_rand      (i_rand),
        .i_ready     (i_ready),
        .o_st        (o_st),
        .o_next_st   (o_next_st),
        .o_at        (o_at),
        .o_done      (o_done),
        .o_valid     (o_valid),
        .o_re_random (o_re_random),
        .o_episode   (o_episode),
        .o_eps       (o_eps),
        .o_busy      (o_busy),
        .o_finish    (o_finish)
    );

    // ---------------- limit instance ----------------
    logic       l_valid;
    logic [3:0] l_first_st  = 4'd0;
    logic [1:0] l_at        = 2'd0;   // always "up"
    logic [7:0] l_rand      = 8'd0;
    logic       l_ready     = 1'b1;
    logic [3:0] l_o_st, l_o_next_st;
    logic [1:0] l_o_at;
    logic       l_o_done, l_o_valid, l_o_re_random, l_o_busy, l_o_finish;
    logic [9:0] l_o_episode;
    logic [7:0] l_o_eps;

    agent_gridworld #(
        .MAX_STEPS  (4),
        .N_EPISODES (2),
        .EPS_INIT   (16)
    ) dut_lim (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (l_valid),
        .i_first_st  (l_first_st),
        .i_at_max    (l_at),
        .i_at_random (l_at),
        .i_rand      (l_rand),
        .i_ready     (l_ready),
        .o_st        (l_o_st),
        .o_next_st   (l_o_next_st),
        .o_at        (l_o_at),
        .o_done      (l_o_done),
        .o_valid     (l_o_valid),
        .o_re_random (l_o_re_random),
        .o_episode   (l_o_episode),
        .o_eps       (l_o_eps),
        .o_busy      (l_o_busy),
        .o_finish    (l_o_finish)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] r, input logic [1:0] amax, input logic [1:0] arand);
        i_rand      = r;
        i_at_max    = amax;
        i_at_random = arand;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int   route_act  [5] = '{1, 1, 1, 3, 3};
    int   route_next [5] = '{5, 9, 13, 14, 15};
    int   route_done [5] = '{0, 0, 0, 0, 1};
    int   idle_bad;
    int   hs_n, fin_n, eps_bad;
    logic [7:0] done_bits;
    logic prev8, fin_after8;

    initial begin
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_first_st = 4'd0;
        i_ready    = 1'b0;
        l_valid    = 1'b0;
        set_in(8'd0, 2'd0, 2'd0);
        tick();
        tick();

        // Reset values
        check("rst_valid",   32'(o_valid),     32'd0);
        check("rst_re",      32'(o_re_random), 32'd0);
        check("rst_busy",    32'(o_busy),      32'd0);
        check("rst_eps",     32'(o_eps),       32'd255);
        check("rst_episode", 32'(o_episode),   32'd0);
        check("rst_finish",  32'(o_finish),    32'd0);

        rst_n = 1'b1;
        tick();

        // Greedy step with cycle-exact timing from start (cycle 0)
        set_in(8'd255, 2'd3, 2'd1);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("c1_re",    32'(o_re_random), 32'd1);
        check("c1_valid", 32'(o_valid),     32'd0);
        tick();
        check("c2_re",    32'(o_re_random), 32'd0);
        check("c2_valid", 32'(o_valid),     32'd0);
        tick();
        check("c3_valid", 32'(o_valid),   32'd1);
        check("g_st",     32'(o_st),      32'd0);
        check("g_at",     32'(o_at),      32'd3);
        check("g_next",   32'(o_next_st), 32'd1);
        check("g_done",   32'(o_done),    32'd0);
        check("g_busy",   32'(o_busy),    32'd1);

        // Backpressure: payload held, no random request
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 32'(o_valid),     32'd1);
            check("bp_re",    32'(o_re_random), 32'd0);
            check("bp_next",  32'(o_next_st),   32'd1);
            check("bp_at",    32'(o_at),        32'd3);
        end
        handshake();
        check("hs_req",   32'(o_re_random), 32'd1);
        check("hs_valid", 32'(o_valid),     32'd0);

        // Random "up" from state 1 clamps at the top wall
        set_in(8'd0, 2'd3, 2'd0);
        wait_valid("rnd");
        check("rnd_st",   32'(o_st),      32'd1);
        check("rnd_at",   32'(o_at),      32'd0);
        check("rnd_next", 32'(o_next_st), 32'd1);
        check("rnd_done", 32'(o_done),    32'd0);
        handshake();

        // Greedy walk 1 -> 5 -> 9 -> 13 -> 14 -> 15 (goal)
        for (int s = 0; s < 5; s++) begin
            set_in(8'd255, 2'(route_act[s]), 2'd0);
            wait_valid("walk");
            check("walk_next", 32'(o_next_st), 32'(route_next[s]));
            check("walk_done", 32'(o_done),    32'(route_done[s]));
            if (s == 4) check("goal_st", 32'(o_st), 32'd14);
            handshake();
        end
        check("ep1_episode", 32'(o_episode), 32'd1);
        check("ep1_eps",     32'(o_eps),     32'd254);
        check("ep1_finish",  32'(o_finish),  32'd0);
        check("ep1_busy",    32'(o_busy),    32'd1);

        // New episode restarts from the first state; 255 >= 254 stays greedy
        set_in(8'd255, 2'd3, 2'd0);
        wait_valid("ep2");
        check("ep2_st",   32'(o_st),      32'd0);
        check("ep2_at",   32'(o_at),      32'd3);
        check("ep2_next", 32'(o_next_st), 32'd1);
        handshake();

        // Epsilon boundary: 253 < 254 explores
        set_in(8'd253, 2'd3, 2'd1);
        wait_valid("eb1");
        check("eb1_at",   32'(o_at),      32'd1);
        check("eb1_next", 32'(o_next_st), 32'd5);
        handshake();

        // Epsilon boundary: 254 is not < 254, greedy left
        set_in(8'd254, 2'd2, 2'd1);
        wait_valid("eb2");
        check("eb2_at",   32'(o_at),      32'd2);
        check("eb2_next", 32'(o_next_st), 32'd4);

        // i_valid outside IDLE has no effect
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("ign_valid", 32'(o_valid), 32'd1);
        check("ign_st",    32'(o_st),    32'd5);

        // Reset mid-run aborts immediately
        rst_n = 1'b0;
        #1;
        check("mrst_valid",   32'(o_valid),     32'd0);
        check("mrst_busy",    32'(o_busy),      32'd0);
        check("mrst_eps",     32'(o_eps),       32'd255);
        check("mrst_episode", 32'(o_episode),   32'd0);
        check("mrst_st",      32'(o_st),        32'd0);
        check("mrst_next",    32'(o_next_st),   32'd0);
        check("mrst_at",      32'(o_at),        32'd0);
        check("mrst_done",    32'(o_done),      32'd0);
        check("mrst_finish",  32'(o_finish),    32'd0);
        tick();
        rst_n = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (o_re_random !== 1'b0 || o_busy !== 1'b0) idle_bad++;
        end
        check("post_rst_idle", 32'(idle_bad), 32'd0);

        // Limits: MAX_STEPS=4, N_EPISODES=2, always up from 0
        hs_n       = 0;
        fin_n      = 0;
        eps_bad    = 0;
        done_bits  = 8'd0;
        prev8      = 1'b0;
        fin_after8 = 1'b0;
        l_valid    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            l_valid = 1'b0;
            if (l_o_finish) begin
                fin_n++;
                if (prev8 && !l_o_busy) fin_after8 = 1'b1;
            end
            prev8 = 1'b0;
            if (l_o_eps !== 8'd16) eps_bad++;
            if (l_o_valid) begin
                if (hs_n < 8) done_bits[hs_n] = l_o_done;
                hs_n++;
                if (hs_n == 8) prev8 = 1'b1;
            end
        end
        check("lim_hs",        32'(hs_n),        32'd8);
        check("lim_done_bits", 32'(done_bits),   32'h88);
        check("lim_fin_cnt",   32'(fin_n),       32'd1);
        check("lim_fin_time",  32'(fin_after8),  32'd1);
        check("lim_episode",   32'(l_o_episode), 32'd2);
        check("lim_busy",      32'(l_o_busy),    32'd0);
        check("lim_eps",       32'(eps_bad),     32'd0);
        check("lim_next",      32'(l_o_next_st), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
